digit_osd_overlay: RTL and testbench

Parametrised on-screen-display overlay for the LCD video path. It draws a row of NUM_CHARS hex glyphs (8x16 font, integer power-of-two scaling) at a programmable origin on top of the incoming 24-bit pixel stream. Character updates are frame-synchronous, through a shadow register. Per-character blinking is driven by a vsync frame counter. It sits after the camera/SDRAM read path and before the LCD timing outputs, and replaces the fixed five-digit overlay.

---
 rtl/osd_pkg.sv | 49 ++++
 rtl/osd_glyph_rom.sv | 16 +
 rtl/digit_osd_overlay.sv | 220 ++++++++++++++++++++++
 tb/tb_digit_osd_overlay.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/osd_pkg.sv
// ---------------------------------------------------------------------------
// osd_pkg
// Shared definitions for the digit OSD overlay:
//   - FONT_ROM      : 16 hex glyphs (0-9, A-F), 8x16 pixels, 128 bits each.
//                     Byte n of a glyph is pixel row n; the byte MSB is the
//                     leftmost pixel, so bit 127 is the top-left pixel.
//   - DEFAULT_FG/BG : default overlay colours.
//   - region_width / region_height : text region extent in pixels for a
//                     given character count and power-of-two magnification.
// ---------------------------------------------------------------------------
package osd_pkg;

  localparam int GLYPH_W = 8;
  localparam int GLYPH_H = 16;

  localparam logic [23:0] DEFAULT_FG = 24'hFFFFFF;
  localparam logic [23:0] DEFAULT_BG = 24'h000000;

  // Index 0 is listed first.
  localparam logic [0:15][127:0] FONT_ROM = {
    128'h0000_3C66_666E_7666_6666_663C_0000_0000, // 0
    128'h0000_1838_7818_1818_1818_187E_0000_0000, // 1
    128'h0000_3C66_0606_0C18_3060_667E_0000_0000, // 2
    128'h0000_3C66_0606_1C06_0606_663C_0000_0000, // 3
    128'h0000_0C1C_3C6C_CCFE_0C0C_0C1E_0000_0000, // 4
    128'h0000_7E60_6060_7C06_0606_663C_0000_0000, // 5
    128'h0000_1C30_6060_7C66_6666_663C_0000_0000, // 6
    128'h0000_7E66_0606_0C18_3030_3030_0000_0000, // 7
    128'h0000_3C66_6666_3C66_6666_663C_0000_0000, // 8
    128'h0000_3C66_6666_3E06_0606_0C38_0000_0000, // 9
    128'h0000_183C_6666_667E_6666_6666_0000_0000, // A
    128'h0000_7C66_6666_7C66_6666_667C_0000_0000, // B
    128'h0000_3C66_6060_6060_6060_663C_0000_0000, // C
    128'h0000_786C_6666_6666_6666_6C78_0000_0000, // D
    128'h0000_7E60_6060_7C60_6060_607E_0000_0000, // E
    128'h0000_7E60_6060_7C60_6060_6060_0000_0000  // F
  };

  // Width in pixels of a row of num_chars glyphs at magnification 2^scale_log2.
  function automatic logic [11:0] region_width(input int num_chars, input int scale_log2);
    return 12'(num_chars * (GLYPH_W << scale_log2));
  endfunction

  // Height in pixels of one glyph row at magnification 2^scale_log2.
  function automatic logic [11:0] region_height(input int scale_log2);
    return 12'(GLYPH_H << scale_log2);
  endfunction

endpackage

// File: rtl/osd_glyph_rom.sv
// ---------------------------------------------------------------------------
// osd_glyph_rom
// Combinational font lookup: 4-bit hex code -> 128-bit glyph bitmap.
//   i_code  [3:0]   hex code of the character
//   o_glyph [127:0] bitmap, bit 127 = top-left, row-major, 8 bits per row
// ---------------------------------------------------------------------------
module osd_glyph_rom
  import osd_pkg::*;
(
  input  logic [3:0]   i_code,
  output logic [127:0] o_glyph
);

  assign o_glyph = FONT_ROM[i_code];

endmodule

// File: rtl/digit_osd_overlay.sv
// ---------------------------------------------------------------------------
// digit_osd_overlay
// Draws NUM_CHARS hex glyphs at (ORIGIN_X, ORIGIN_Y), magnified 2^SCALE_LOG2,
// over a 24-bit pixel stream. Fixed 2-cycle latency on all outputs.
//
// Ports
//   clk, rst_n            pixel clock, asynchronous active-low reset
//   x, y [11:0]           pixel position aligned with i_data
//   i_hs, i_vs, i_de      input syncs (vsync active high)
//   i_data [23:0]         input pixel
//   enable                overlay on (0: pass-through after the pipeline)
//   opaque                1: clear glyph bits show BG_COLOR, 0: show i_data
//   chars [4*N-1:0]       char k = chars[4k+3:4k], char 0 leftmost
//   blink_mask [N-1:0]    bit k set: char k blinks
//   load                  strobe capturing chars/blink_mask into pending regs
//   o_hs, o_vs, o_de      syncs delayed by 2 cycles
//   o_data [23:0]         composited pixel
//
// Stream protocol: one pixel per clock, every clock, no back-pressure; every
// input is sampled on each rising clk edge and the matching output appears
// exactly two edges later. enable and opaque are sampled with the pixel.
//
// Character and blink-mask updates go through a pending/active shadow pair;
// active only changes on a vsync rising edge, so a frame never tears.
// ---------------------------------------------------------------------------
module digit_osd_overlay
  import osd_pkg::*;
#(
  parameter int          NUM_CHARS    = 5,
  parameter int          SCALE_LOG2   = 2,
  parameter int          ORIGIN_X     = 0,
  parameter int          ORIGIN_Y     = 0,
  parameter logic [23:0] FG_COLOR     = DEFAULT_FG,
  parameter logic [23:0] BG_COLOR     = DEFAULT_BG,
  parameter int          BLINK_FRAMES = 30
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [11:0]            x,
  input  logic [11:0]            y,
  input  logic                   i_hs,
  input  logic                   i_vs,
  input  logic                   i_de,
  input  logic [23:0]            i_data,
  input  logic                   enable,
  input  logic                   opaque,
  input  logic [4*NUM_CHARS-1:0] chars,
  input  logic [NUM_CHARS-1:0]   blink_mask,
  input  logic                   load,
  output logic                   o_hs,
  output logic                   o_vs,
  output logic                   o_de,
  output logic [23:0]            o_data
);

  localparam logic [11:0] ORG_X = 12'(ORIGIN_X);
  localparam logic [11:0] ORG_Y = 12'(ORIGIN_Y);
  localparam logic [11:0] REG_W = region_width(NUM_CHARS, SCALE_LOG2);
  localparam logic [11:0] REG_H = region_height(SCALE_LOG2);

  // A one-frame blink period still needs a 1-bit counter.
  localparam int               CNT_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

  // -------------------------------------------------------------------------
  // Shadow registers, vsync edge detect, blink frame counter
  // -------------------------------------------------------------------------
  logic                   r_vs_q;
  logic                   w_vs_rise;
  logic [4*NUM_CHARS-1:0] r_pend_chars;
  logic [NUM_CHARS-1:0]   r_pend_mask;
  logic [4*NUM_CHARS-1:0] r_act_chars;
  logic [NUM_CHARS-1:0]   r_act_mask;
  logic [CNT_W-1:0]       r_frame_cnt;
  logic                   r_blink_phase;

  assign w_vs_rise = i_vs & ~r_vs_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vs_q        <= 1'b0;
      r_pend_chars  <= '0;
      r_pend_mask   <= '0;
      r_act_chars   <= '0;
      r_act_mask    <= '0;
      r_frame_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else begin
      r_vs_q <= i_vs;
      if (load) begin
        r_pend_chars <= chars;
        r_pend_mask  <= blink_mask;
      end
      if (w_vs_rise) begin
        // A load on the rise cycle bypasses pending so it is not a frame late.
        r_act_chars <= load ? chars      : r_pend_chars;
        r_act_mask  <= load ? blink_mask : r_pend_mask;
        if (r_frame_cnt == CNT_LAST) begin
          r_frame_cnt   <= '0;
          r_blink_phase <= ~r_blink_phase;
        end else begin
          r_frame_cnt <= r_frame_cnt + 1'b1;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Stage 1: region test, character select, glyph row/column
  // -------------------------------------------------------------------------
  logic [11:0] w_dx;
  logic [11:0] w_dy;
  logic        w_in_x;
  logic        w_in_y;
  logic [3:0]  w_char_idx;
  logic [2:0]  w_col;
  logic [3:0]  w_row;
  logic [3:0]  w_code;
  logic        w_blinks;
  logic        w_visible;

  // Positions left of / above the origin wrap to large offsets, so a single
  // unsigned upper-bound compare covers both sides of the region.
  assign w_dx       = x - ORG_X;
  assign w_dy       = y - ORG_Y;
  assign w_in_x     = (w_dx < REG_W);
  assign w_in_y     = (w_dy < REG_H);
  assign w_char_idx = 4'(w_dx >> (3 + SCALE_LOG2));
  assign w_col      = 3'(w_dx >> SCALE_LOG2);
  assign w_row      = 4'(w_dy >> SCALE_LOG2);

  always_comb begin
    w_code   = '0;
    w_blinks = 1'b0;
    for (int k = 0; k < NUM_CHARS; k++) begin
      if (w_char_idx == 4'(k)) begin
        w_code   = r_act_chars[4*k +: 4];
        w_blinks = r_act_mask[k];
      end
    end
  end

  // A blinked-off character is treated exactly like a pixel outside the text.
  assign w_visible = enable & w_in_x & w_in_y & ~(w_blinks & r_blink_phase);

  logic        r1_visible;
  logic        r1_opaque;
  logic [3:0]  r1_code;
  logic [3:0]  r1_row;
  logic [2:0]  r1_col;
  logic [23:0] r1_data;
  logic        r1_hs;
  logic        r1_vs;
  logic        r1_de;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_visible <= 1'b0;
      r1_opaque  <= 1'b0;
      r1_code    <= '0;
      r1_row     <= '0;
      r1_col     <= '0;
      r1_data    <= '0;
      r1_hs      <= 1'b0;
      r1_vs      <= 1'b0;
      r1_de      <= 1'b0;
    end else begin
      r1_visible <= w_visible;
      r1_opaque  <= opaque;
      r1_code    <= w_code;
      r1_row     <= w_row;
      r1_col     <= w_col;
      r1_data    <= i_data;
      r1_hs      <= i_hs;
      r1_vs      <= i_vs;
      r1_de      <= i_de;
    end
  end

  // -------------------------------------------------------------------------
  // Stage 2: glyph bit select and colour mux
  // -------------------------------------------------------------------------
  logic [127:0] w_glyph;
  logic         w_bit;
  logic [23:0]  w_pix;

  osd_glyph_rom u_rom (
    .i_code  (r1_code),
    .o_glyph (w_glyph)
  );

  // 127 - (8*row + col) is the bitwise inverse of the 7-bit {row, col}.
  assign w_bit = w_glyph[~{r1_row, r1_col}];

  always_comb begin
    w_pix = r1_data;
    if (r1_visible) begin
      if (w_bit) begin
        w_pix = FG_COLOR;
      end else if (r1_opaque) begin
        w_pix = BG_COLOR;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_data <= '0;
      o_hs   <= 1'b0;
      o_vs   <= 1'b0;
      o_de   <= 1'b0;
    end else begin
      o_data <= w_pix;
      o_hs   <= r1_hs;
      o_vs   <= r1_vs;
      o_de   <= r1_de;
    end
  end

endmodule

// File: tb/tb_digit_osd_overlay.sv
// ---------------------------------------------------------------------------
// tb_digit_osd_overlay
// Directed test of digit_osd_overlay. Instance u_dut_a uses the default
// geometry (5 chars, 4x scale, origin 0,0) with BLINK_FRAMES=2; instance
// u_dut_b is a single unscaled char at x=100. Both share the pixel stream.
// Expected outputs are hand-derived from the font table and pushed into
// exp_q; each is popped and compared two clocks later.
// ---------------------------------------------------------------------------
module tb_digit_osd_overlay;

  localparam logic [23:0] FG = 24'hFFFFFF;
  localparam logic [23:0] BG = 24'h000000;
  localparam logic [23:0] D  = 24'h123456;
  localparam logic [23:0] VD = 24'h0F0F0F;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // stimulus
  logic [11:0] x, y;
  logic        i_hs, i_vs, i_de;
  logic [23:0] i_data;
  logic        en_a, en_b, opaque, load;
  logic [19:0] chars;
  logic [4:0]  blink_mask;
  logic [3:0]  chars_b;
  logic [0:0]  mask_b;

  // observed
  logic        o_hs, o_vs, o_de, o_hs_b, o_vs_b, o_de_b;
  logic [23:0] o_data, o_data_b;

  digit_osd_overlay #(
    .NUM_CHARS(5), .SCALE_LOG2(2), .ORIGIN_X(0), .ORIGIN_Y(0),
    .FG_COLOR(24'hFFFFFF), .BG_COLOR(24'h000000), .BLINK_FRAMES(2)
  ) u_dut_a (
    .clk(clk), .rst_n(rst_n), .x(x), .y(y),
    .i_hs(i_hs), .i_vs(i_vs), .i_de(i_de), .i_data(i_data),
    .enable(en_a), .opaque(opaque), .chars(chars), .blink_mask(blink_mask),
    .load(load), .o_hs(o_hs), .o_vs(o_vs), .o_de(o_de), .o_data(o_data)
  );

  digit_osd_overlay #(
    .NUM_CHARS(1), .SCALE_LOG2(0), .ORIGIN_X(100), .ORIGIN_Y(0),
    .FG_COLOR(24'hFFFFFF), .BG_COLOR(24'h000000), .BLINK_FRAMES(2)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n), .x(x), .y(y),
    .i_hs(i_hs), .i_vs(i_vs), .i_de(i_de), .i_data(i_data),
    .enable(en_b), .opaque(opaque), .chars(chars_b), .blink_mask(mask_b),
    .load(load), .o_hs(o_hs_b), .o_vs(o_vs_b), .o_de(o_de_b), .o_data(o_data_b)
  );

  // scoreboard: {hs, vs, de, data_a, data_b}
  logic [50:0] exp_q[$];
  int n_total = 0;
  int n_bad   = 0;

  task automatic check_eq(input string tag, input logic [23:0] got, input logic [23:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Drive one pixel now (at a falling edge), then at the next falling edge
  // compare the outputs belonging to the pixel driven one call earlier.
  task automatic pix(input logic [11:0] px, input logic [11:0] py,
                     input logic hs, input logic vs, input logic de,
                     input logic [23:0] d, input logic [23:0] ea, input logic [23:0] eb);
    logic [50:0] e;
    x = px; y = py; i_hs = hs; i_vs = vs; i_de = de; i_data = d;
    exp_q.push_back({hs, vs, de, ea, eb});
    @(negedge clk);
    if (exp_q.size() >= 2) begin
      e = exp_q.pop_front();
      check_eq("sync_a", {21'd0, o_hs, o_vs, o_de}, {21'd0, e[50:48]});
      check_eq("data_a", o_data, e[47:24]);
      check_eq("sync_b", {21'd0, o_hs_b, o_vs_b, o_de_b}, {21'd0, e[50:48]});
      check_eq("data_b", o_data_b, e[23:0]);
    end
  endtask

  // Active pixel, u_dut_b expected to pass through.
  task automatic px_a(input logic [11:0] px, input logic [11:0] py, input logic [23:0] ea);
    pix(px, py, 1'b0, 1'b0, 1'b1, D, ea, D);
  endtask

  // Active pixel, u_dut_a expected to pass through.
  task automatic px_b(input logic [11:0] px, input logic [11:0] py, input logic [23:0] eb);
    pix(px, py, 1'b0, 1'b0, 1'b1, D, D, eb);
  endtask

  task automatic hblank();
    pix(12'd4000, 12'd4000, 1'b1, 1'b0, 1'b0, VD, VD, VD);
    load = 1'b0;
  endtask

  // Three vsync lines then one blank; a caller-raised load covers the rise cycle only.
  task automatic vsync();
    for (int i = 0; i < 3; i++) begin
      pix(12'd4000, 12'd4000, 1'b0, 1'b1, 1'b0, VD, VD, VD);
      load = 1'b0;
    end
    pix(12'd4000, 12'd4000, 1'b0, 1'b0, 1'b0, VD, VD, VD);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    x = '0; y = '0; i_hs = 0; i_vs = 0; i_de = 0; i_data = '0;
    en_a = 1'b1; en_b = 1'b0; opaque = 1'b1; load = 1'b0;
    chars = '0; blink_mask = '0; chars_b = '0; mask_b = '0;

    // reset state
    repeat (2) @(negedge clk);
    check_eq("rst_data_a", o_data, 24'h0);
    check_eq("rst_sync_a", {21'd0, o_hs, o_vs, o_de}, 24'h0);
    check_eq("rst_data_b", o_data_b, 24'h0);
    check_eq("rst_sync_b", {21'd0, o_hs_b, o_vs_b, o_de_b}, 24'h0);
    rst_n = 1'b1;

    // load 01234 before the first vsync: char0='4' .. char3='1', char4='0'
    chars = 20'h01234; chars_b = 4'h1; load = 1'b1;
    hblank();
    vsync();
    px_a(12'd0,   12'd0,  BG);   // '4' top row empty
    px_a(12'd104, 12'd12, FG);   // '1' row3 col2
    px_a(12'd100, 12'd12, BG);   // '1' row3 col1
    px_a(12'd107, 12'd15, FG);   // same 4x4 block as (104,12)
    px_a(12'd108, 12'd15, FG);   // '1' row3 col3
    px_a(12'd112, 12'd12, FG);   // '1' row3 col4
    px_a(12'd116, 12'd12, BG);   // '1' row3 col5
    px_a(12'd40,  12'd8,  FG);   // '3' row2 col2
    px_a(12'd36,  12'd8,  BG);   // '3' row2 col1
    px_a(12'd52,  12'd9,  FG);   // '3' row2 col5
    px_a(12'd60,  12'd10, BG);   // '3' row2 col7
    px_a(12'd132, 12'd20, FG);   // '0' row5 col1
    px_a(12'd140, 12'd20, BG);   // '0' row5 col3
    px_a(12'd148, 12'd21, FG);   // '0' row5 col5
    px_a(12'd156, 12'd23, BG);   // '0' row5 col7
    px_a(12'd159, 12'd63, BG);   // last region pixel
    px_a(12'd160, 12'd0,  D);    // right of region
    px_a(12'd0,   12'd64, D);    // below region
    hblank();

    // mid-frame load of ABCDE: char1='D', char3='B' only from next frame
    chars = 20'hABCDE; load = 1'b1;
    px_a(12'd52,  12'd9,  FG);
    load = 1'b0;
    px_a(12'd112, 12'd12, FG);
    px_a(12'd52,  12'd9,  FG);
    hblank();
    vsync();
    px_a(12'd52,  12'd9,  BG);   // 'D' row2 col5
    px_a(12'd112, 12'd12, BG);   // 'B' row3 col4
    px_a(12'd40,  12'd8,  FG);   // 'D' row2 col2

    // load coinciding with the vs rise applies to the frame it starts
    chars = 20'h01234; load = 1'b1;
    vsync();
    px_a(12'd52,  12'd9,  FG);
    px_a(12'd112, 12'd12, FG);
    vsync();
    px_a(12'd52,  12'd9,  FG);   // pending holds the same value

    // transparent mode, then overlay disabled
    opaque = 1'b0;
    px_a(12'd104, 12'd12, FG);
    px_a(12'd100, 12'd12, D);
    px_a(12'd36,  12'd8,  D);
    en_a = 1'b0;
    px_a(12'd104, 12'd12, D);
    px_a(12'd52,  12'd9,  D);
    px_a(12'd0,   12'd0,  D);
    hblank();

    // single unscaled char at x=100: '1' row3 = cols 2..4 lit
    opaque = 1'b1; en_b = 1'b1;
    px_b(12'd99,  12'd3,  D);
    px_b(12'd100, 12'd3,  BG);
    px_b(12'd102, 12'd3,  FG);
    px_b(12'd104, 12'd3,  FG);
    px_b(12'd105, 12'd3,  BG);
    px_b(12'd107, 12'd3,  BG);
    px_b(12'd108, 12'd3,  D);
    px_b(12'd103, 12'd5,  FG);   // '1' row5 col3
    px_b(12'd102, 12'd16, D);    // below the glyph
    en_b = 1'b0; en_a = 1'b1;
    hblank();

    // asynchronous reset mid-line
    px_a(12'd40, 12'd8, FG);
    px_a(12'd40, 12'd8, FG);
    #1 rst_n = 1'b0;
    #1;
    check_eq("midrst_data", o_data, 24'h0);
    check_eq("midrst_sync", {21'd0, o_hs, o_vs, o_de}, 24'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    px_a(12'd4,  12'd20, FG);    // all chars now '0': row5 col1
    px_a(12'd12, 12'd20, BG);    // row5 col3
    px_a(12'd36, 12'd20, FG);    // char1 row5 col1
    hblank();

    // blink char 2 ('2', row2 col2 lit at (72,8)); frame n = after n rises
    chars = 20'h01234; blink_mask = 5'b00100; load = 1'b1;
    hblank();
    vsync();                       // frame 1: visible
    px_a(12'd72, 12'd8, FG);
    px_a(12'd52, 12'd9, FG);
    vsync();                       // frame 2: hidden
    px_a(12'd72, 12'd8, D);
    px_a(12'd52, 12'd9, FG);
    vsync();                       // frame 3: hidden
    px_a(12'd72, 12'd8, D);
    vsync();                       // frame 4: visible
    px_a(12'd72, 12'd8, FG);
    vsync();                       // frame 5: visible
    px_a(12'd72, 12'd8, FG);
    vsync();                       // frame 6: hidden
    px_a(12'd72, 12'd8, D);

    // drain the pipeline
    hblank();
    hblank();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
